dm9000a_bus_sequencer: RTL

Hardware sequencer and two-port arbiter for the DM9000A host bus. It accepts register read/write requests from two requesters, for example the Nios II host path and a packet DMA engine. Each access runs as the chip's two-phase index/data cycle: an index write with CMD=0, then a data read or write with CMD=1. Parameterized setup/strobe/hold timing is applied to both phases, and all strobes are driven from registers. The block sits between the requesters and the ENET pad ring, replacing direct pass-through of Avalon strobes.

---
 rtl/dm9000a_bus_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dm9000a_bus_sequencer.sv
// DM9000A host-bus sequencer: two-requester round-robin arbiter driving the
// chip's index/data cycle with parameterised setup/strobe/hold timing.
// Every pad-facing signal and every handshake output comes straight from a flop.
module dm9000a_bus_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iREQ0,
    input  logic        iREQ1,
    input  logic        iWE0,
    input  logic        iWE1,
    input  logic [7:0]  iIDX0,
    input  logic [7:0]  iIDX1,
    input  logic [15:0] iWDATA0,
    input  logic [15:0] iWDATA1,
    output logic        oACK0,
    output logic        oACK1,
    output logic [15:0] oRDATA,
    output logic        oBUSY,
    output logic        oENET_CMD,
    output logic        oENET_CS_N,
    output logic        oENET_RD_N,
    output logic        oENET_WR_N,
    output logic [15:0] oENET_DOUT,
    output logic        oENET_DOE,
    input  logic [15:0] iENET_DIN
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_I_SETUP = 3'd1;
    localparam logic [2:0] S_I_STRB  = 3'd2;
    localparam logic [2:0] S_I_HOLD  = 3'd3;
    localparam logic [2:0] S_D_SETUP = 3'd4;
    localparam logic [2:0] S_D_STRB  = 3'd5;
    localparam logic [2:0] S_D_HOLD  = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    // Counter reload values: a state lasting N cycles loads N-1 on entry.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             cnt_zero;
    logic             last_gnt;
    logic             gnt_sel;
    logic             sel_d;
    logic             take;
    logic             win;
    logic [7:0]       idx_q;
    logic [7:0]       idx_d;
    logic             we_q;
    logic             we_d;
    logic [15:0]      wdata_q;
    logic [15:0]      wdata_d;
    logic             in_idx;
    logic             in_dat;
    logic             cs_n_d;
    logic             rd_n_d;
    logic             wr_n_d;
    logic             cmd_d;
    logic             doe_d;
    logic [15:0]      dout_d;
    logic             ack0_d;
    logic             ack1_d;
    logic             busy_d;
    logic             cap_rd;

    // Next state, arbitration, grant capture and decode of next-cycle outputs.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        take     = 1'b0;
        cnt_zero = (cnt == '0);
        win      = 1'b0;
        if (iREQ0 && iREQ1) begin
            win = ~last_gnt;
        end else if (iREQ1) begin
            win = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (iREQ0 || iREQ1) begin
                    take    = 1'b1;
                    state_d = S_I_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_I_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_I_STRB;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_I_STRB: begin
                if (cnt_zero) begin
                    state_d = S_I_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_I_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_D_SETUP;
                    cnt_d   = SETUP_LD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_D_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_D_STRB;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_D_STRB: begin
                if (cnt_zero) begin
                    state_d = S_D_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_D_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Access fields are frozen at the grant edge; later input changes are ignored.
        sel_d   = take ? win : gnt_sel;
        idx_d   = take ? (win ? iIDX1 : iIDX0) : idx_q;
        we_d    = take ? (win ? iWE1 : iWE0) : we_q;
        wdata_d = take ? (win ? iWDATA1 : iWDATA0) : wdata_q;

        in_idx = (state_d == S_I_SETUP) || (state_d == S_I_STRB) || (state_d == S_I_HOLD);
        in_dat = (state_d == S_D_SETUP) || (state_d == S_D_STRB) || (state_d == S_D_HOLD);

        cs_n_d = ~(in_idx | in_dat);
        wr_n_d = ~((state_d == S_I_STRB) | ((state_d == S_D_STRB) & we_d));
        rd_n_d = ~((state_d == S_D_STRB) & ~we_d);
        cmd_d  = in_dat;
        doe_d  = in_idx | (in_dat & we_d);
        dout_d = in_idx ? {8'h00, idx_d} : ((in_dat & we_d) ? wdata_d : 16'h0000);
        ack0_d = (state_d == S_DONE) & ~sel_d;
        ack1_d = (state_d == S_DONE) & sel_d;
        busy_d = (state_d != S_IDLE);

        // Read data is taken on the edge that ends the data strobe.
        cap_rd = (state == S_D_STRB) && cnt_zero && !we_q;
    end

    // State, captured access and registered pad/handshake outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_gnt   <= 1'b1;
            gnt_sel    <= 1'b0;
            idx_q      <= 8'h00;
            we_q       <= 1'b0;
            wdata_q    <= 16'h0000;
            oENET_CS_N <= 1'b1;
            oENET_RD_N <= 1'b1;
            oENET_WR_N <= 1'b1;
            oENET_CMD  <= 1'b0;
            oENET_DOE  <= 1'b0;
            oENET_DOUT <= 16'h0000;
            oACK0      <= 1'b0;
            oACK1      <= 1'b0;
            oBUSY      <= 1'b0;
            oRDATA     <= 16'h0000;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            if (take) begin
                last_gnt <= win;
            end
            gnt_sel    <= sel_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            oENET_CS_N <= cs_n_d;
            oENET_RD_N <= rd_n_d;
            oENET_WR_N <= wr_n_d;
            oENET_CMD  <= cmd_d;
            oENET_DOE  <= doe_d;
            oENET_DOUT <= dout_d;
            oACK0      <= ack0_d;
            oACK1      <= ack1_d;
            oBUSY      <= busy_d;
            if (cap_rd) begin
                oRDATA <= iENET_DIN;
            end
        end
    end

endmodule
